// File: rtl/lcd_pkg.sv
// Shared colour constants and bounce direction type for the LCD pattern source.
// Pure declarations; no logic, no latency, no flow control.
// Imported by the bounce axis and the top-level colour mux.
package lcd_pkg;

    localparam logic [23:0] WHITE   = 24'hFFFFFF;
    localparam logic [23:0] BLACK   = 24'h000000;
    localparam logic [23:0] RED     = 24'hFF0000;
    localparam logic [23:0] GREEN   = 24'h00FF00;
    localparam logic [23:0] BLUE    = 24'h0000FF;
    localparam logic [23:0] YELLOW  = 24'hFFFF00;
    localparam logic [23:0] CYAN    = 24'h00FFFF;
    localparam logic [23:0] MAGENTA = 24'hFF00FF;

    typedef enum logic {
        INC = 1'b0,
        DEC = 1'b1
    } dir_t;

endpackage

// File: rtl/lcd_bounce_axis.sv
// One axis of the bouncing square: INC/DEC FSM with clamping to [1, LIMIT-BOX_SIZE+1].
// Position updates on the edge where step_en is high; 1 cycle from step_en to new pos.
// No backpressure; step_en is a single-cycle strobe from the frame-end detector.
module lcd_bounce_axis
    import lcd_pkg::*;
#(
    parameter logic [10:0] LIMIT    = 11'd480,
    parameter logic [10:0] BOX_SIZE = 11'd32,
    parameter logic [10:0] STEP     = 11'd2
) (
    input  logic        lcd_clk,
    input  logic        sys_rst,
    input  logic        step_en,
    output logic [10:0] pos,
    output logic        dir
);

    localparam logic [10:0] MAX = LIMIT - BOX_SIZE + 11'd1;

    logic [10:0] pos_q, pos_d;
    dir_t        dir_q, dir_d;

    always_ff @(posedge lcd_clk or posedge sys_rst) begin
        if (sys_rst) begin
            pos_q <= 11'd1;
            dir_q <= INC;
        end else begin
            pos_q <= pos_d;
            dir_q <= dir_d;
        end
    end

    // Clamp to the edge and turn around in the same frame the limit is reached.
    always_comb begin
        pos_d = pos_q;
        dir_d = dir_q;
        if (step_en) begin
            case (dir_q)
                INC: begin
                    if (pos_q + STEP >= MAX) begin
                        pos_d = MAX;
                        dir_d = DEC;
                    end else begin
                        pos_d = pos_q + STEP;
                    end
                end
                DEC: begin
                    if (pos_q <= 11'd1 + STEP) begin
                        pos_d = 11'd1;
                        dir_d = INC;
                    end else begin
                        pos_d = pos_q - STEP;
                    end
                end
                default: begin
                    pos_d = 11'd1;
                    dir_d = INC;
                end
            endcase
        end
    end

    assign pos = pos_q;
    assign dir = dir_q;

endmodule

// File: rtl/lcd_bounce_box.sv
// Pixel source: 8 colour bars with a bouncing square, keyed off driver request coordinates.
// pixel_data is registered, 1 lcd_clk after the coordinate; square moves only at frame end.
// No backpressure; the driver requests one coordinate per cycle unconditionally.
module lcd_bounce_box
    import lcd_pkg::*;
#(
    parameter logic [10:0] H_DISP    = 11'd480,
    parameter logic [10:0] V_DISP    = 11'd272,
    parameter logic [10:0] BOX_SIZE  = 11'd32,
    parameter logic [10:0] STEP      = 11'd2,
    parameter logic [23:0] BOX_COLOR = 24'hFF0000
) (
    input  logic        lcd_clk,
    input  logic        sys_rst,
    input  logic [10:0] pixel_xpos,
    input  logic [10:0] pixel_ypos,
    input  logic        run,
    output logic [23:0] pixel_data,
    output logic [15:0] frame_cnt
);

    localparam logic [10:0] BAR_W = H_DISP / 11'd8;
    localparam logic [10:0] B1 = BAR_W;
    localparam logic [10:0] B2 = BAR_W * 11'd2;
    localparam logic [10:0] B3 = BAR_W * 11'd3;
    localparam logic [10:0] B4 = BAR_W * 11'd4;
    localparam logic [10:0] B5 = BAR_W * 11'd5;
    localparam logic [10:0] B6 = BAR_W * 11'd6;
    localparam logic [10:0] B7 = BAR_W * 11'd7;

    logic [23:0] pixel_data_q, pixel_data_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        fe_q, fe_d;
    logic [10:0] box_x, box_y;
    logic        dir_x, dir_y;
    logic        step_en;
    logic        in_box;

    assign step_en = fe_q & run;

    lcd_bounce_axis #(
        .LIMIT    (H_DISP),
        .BOX_SIZE (BOX_SIZE),
        .STEP     (STEP)
    ) u_axis_x (
        .lcd_clk (lcd_clk),
        .sys_rst (sys_rst),
        .step_en (step_en),
        .pos     (box_x),
        .dir     (dir_x)
    );

    lcd_bounce_axis #(
        .LIMIT    (V_DISP),
        .BOX_SIZE (BOX_SIZE),
        .STEP     (STEP)
    ) u_axis_y (
        .lcd_clk (lcd_clk),
        .sys_rst (sys_rst),
        .step_en (step_en),
        .pos     (box_y),
        .dir     (dir_y)
    );

    assign in_box = (pixel_xpos >= box_x) && (pixel_xpos < box_x + BOX_SIZE) &&
                    (pixel_ypos >= box_y) && (pixel_ypos < box_y + BOX_SIZE);

    // Bars resolved by a compare chain; anything past bar 6 falls into bar 7.
    always_comb begin
        pixel_data_d = BLACK;
        if (pixel_xpos == 11'd0 || pixel_ypos == 11'd0) begin
            pixel_data_d = BLACK;
        end else if (in_box) begin
            pixel_data_d = BOX_COLOR;
        end else if (pixel_xpos <= B1) begin
            pixel_data_d = WHITE;
        end else if (pixel_xpos <= B2) begin
            pixel_data_d = BLACK;
        end else if (pixel_xpos <= B3) begin
            pixel_data_d = RED;
        end else if (pixel_xpos <= B4) begin
            pixel_data_d = GREEN;
        end else if (pixel_xpos <= B5) begin
            pixel_data_d = BLUE;
        end else if (pixel_xpos <= B6) begin
            pixel_data_d = YELLOW;
        end else if (pixel_xpos <= B7) begin
            pixel_data_d = CYAN;
        end else begin
            pixel_data_d = MAGENTA;
        end
    end

    always_comb begin
        fe_d        = (pixel_xpos == H_DISP) && (pixel_ypos == V_DISP);
        frame_cnt_d = frame_cnt_q;
        if (fe_q) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge lcd_clk or posedge sys_rst) begin
        if (sys_rst) begin
            pixel_data_q <= 24'd0;
            frame_cnt_q  <= 16'd0;
            fe_q         <= 1'b0;
        end else begin
            pixel_data_q <= pixel_data_d;
            frame_cnt_q  <= frame_cnt_d;
            fe_q         <= fe_d;
        end
    end

    assign pixel_data = pixel_data_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_lcd_bounce_box.sv
// Directed bench for lcd_bounce_box: expected pixels queued at request time, checked one cycle later.
// A small behavioural model tracks box position, direction and frame count.
module tb_lcd_bounce_box;

    logic        lcd_clk = 1'b0;
    logic        sys_rst = 1'b0;
    logic [10:0] pixel_xpos = 11'd0;
    logic [10:0] pixel_ypos = 11'd0;
    logic        run = 1'b1;
    logic [23:0] pixel_data;
    logic [15:0] frame_cnt;

    always #5 lcd_clk = ~lcd_clk;

    lcd_bounce_box dut (
        .lcd_clk    (lcd_clk),
        .sys_rst    (sys_rst),
        .pixel_xpos (pixel_xpos),
        .pixel_ypos (pixel_ypos),
        .run        (run),
        .pixel_data (pixel_data),
        .frame_cnt  (frame_cnt)
    );

    typedef struct {
        bit          chk;
        logic [23:0] exp;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int errors = 0;
    int checks = 0;
    int bx = 1, by = 1, vx = 2, vy = 2;
    int fc = 0;

    function automatic logic [23:0] mcol(input int x, input int y);
        int i;
        if (x == 0 || y == 0) return 24'h000000;
        if (x >= bx && x < bx + 32 && y >= by && y < by + 32) return 24'hFF0000;
        i = (x - 1) / 60;
        if (i > 7) i = 7;
        case (i)
            0: return 24'hFFFFFF;
            1: return 24'h000000;
            2: return 24'hFF0000;
            3: return 24'h00FF00;
            4: return 24'h0000FF;
            5: return 24'hFFFF00;
            6: return 24'h00FFFF;
            default: return 24'hFF00FF;
        endcase
    endfunction

    task automatic check24(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One request per cycle: compare the result of the previous request, then drive the next.
    task automatic step(input int x, input int y, input bit chk, input logic [23:0] e, input string tag);
        exp_t ent;
        @(negedge lcd_clk);
        if (sb.size() > 0) begin
            ent = sb.pop_front();
            if (ent.chk) check24(ent.tag, pixel_data, ent.exp);
        end
        pixel_xpos = x[10:0];
        pixel_ypos = y[10:0];
        ent.chk = chk;
        ent.exp = e;
        ent.tag = tag;
        sb.push_back(ent);
    endtask

    task automatic stepm(input int x, input int y, input string tag);
        step(x, y, 1'b1, mcol(x, y), tag);
    endtask

    task automatic frame_end(input bit r, input string tag);
        run = r;
        stepm(480, 272, {tag, "_fe_px"});
        step(0, 0, 1'b1, 24'h000000, {tag, "_blank0"});
        step(0, 0, 1'b1, 24'h000000, {tag, "_blank1"});
        fc = (fc + 1) & 16'hFFFF;
        if (r) begin
            bx += vx;
            if (bx >= 449) begin bx = 449; vx = -2; end
            else if (bx <= 1) begin bx = 1; vx = 2; end
            by += vy;
            if (by >= 241) begin by = 241; vy = -2; end
            else if (by <= 1) begin by = 1; vy = 2; end
        end
        check16({tag, "_frame_cnt"}, frame_cnt, fc[15:0]);
    endtask

    task automatic probe_box(input string tag);
        stepm(bx, by, {tag, "_tl"});
        stepm(bx + 31, by + 31, {tag, "_br"});
        stepm(bx - 1, by, {tag, "_left"});
        stepm(bx, by - 1, {tag, "_above"});
        if (bx + 32 <= 480) stepm(bx + 32, by, {tag, "_right"});
        if (by + 32 <= 272) stepm(bx, by + 32, {tag, "_below"});
    endtask

    initial begin
        // Power-on reset, checked before any clock edge.
        #2 sys_rst = 1'b1;
        #1;
        check24("rst_pixel", pixel_data, 24'h000000);
        check16("rst_frame_cnt", frame_cnt, 16'h0000);
        repeat (3) @(posedge lcd_clk);
        @(negedge lcd_clk);
        sys_rst = 1'b0;

        // Bars and one-cycle latency.
        step(61, 100, 1'b1, 24'h000000, "bar1_start");
        step(121, 100, 1'b1, 24'hFF0000, "bar2_start");
        step(480, 100, 1'b1, 24'hFF00FF, "bar7_end");
        step(60, 100, 1'b1, 24'hFFFFFF, "bar0_end");
        step(0, 100, 1'b1, 24'h000000, "x_zero");
        step(100, 0, 1'b1, 24'h000000, "y_zero");
        step(400, 100, 1'b1, 24'h00FFFF, "bar6");
        step(200, 100, 1'b1, 24'h00FF00, "bar3");
        step(250, 100, 1'b1, 24'h0000FF, "bar4");
        step(350, 100, 1'b1, 24'hFFFF00, "bar5");

        // Box overlay at its reset position.
        step(1, 1, 1'b1, 24'hFF0000, "box_tl");
        step(32, 32, 1'b1, 24'hFF0000, "box_br");
        step(33, 1, 1'b1, 24'hFFFFFF, "box_right");
        step(1, 33, 1'b1, 24'hFFFFFF, "box_below");
        step(100, 100, 1'b1, 24'h000000, "box_bar1");

        // Frame end with run=1 moves to (3,3); with run=0 the square holds.
        frame_end(1'b1, "fe_run");
        step(3, 3, 1'b1, 24'hFF0000, "mv_tl");
        step(2, 3, 1'b1, 24'hFFFFFF, "mv_left");
        step(3, 2, 1'b1, 24'hFFFFFF, "mv_above");
        step(34, 34, 1'b1, 24'hFF0000, "mv_br");
        step(35, 3, 1'b1, 24'hFFFFFF, "mv_right");
        frame_end(1'b0, "fe_hold");
        step(3, 3, 1'b1, 24'hFF0000, "hold_tl");
        step(2, 3, 1'b1, 24'hFFFFFF, "hold_left");
        step(35, 3, 1'b1, 24'hFFFFFF, "hold_right");
        step(40, 100, 1'b1, 24'hFFFFFF, "pre_rst");

        // Asynchronous reset mid-stream, away from any clock edge.
        @(posedge lcd_clk);
        #2;
        check24("pre_rst_white", pixel_data, 24'hFFFFFF);
        sys_rst = 1'b1;
        #1;
        check24("async_rst_pixel", pixel_data, 24'h000000);
        check16("async_rst_frame_cnt", frame_cnt, 16'h0000);
        sb.delete();
        bx = 1; by = 1; vx = 2; vy = 2; fc = 0;
        repeat (2) @(posedge lcd_clk);
        @(negedge lcd_clk);
        sys_rst = 1'b0;
        step(1, 1, 1'b1, 24'hFF0000, "post_rst_tl");
        step(33, 1, 1'b1, 24'hFFFFFF, "post_rst_right");
        step(3, 34, 1'b1, 24'hFFFFFF, "post_rst_below");

        // 250 frames of bouncing from the reset position.
        for (int f = 1; f <= 250; f++) begin
            frame_end(1'b1, "bounce");
            probe_box("bounce");
            if (f == 120) begin
                step(bx, 241, 1'b1, 24'hFF0000, "y241_top");
                step(bx, 272, 1'b1, 24'hFF0000, "y241_bottom_row");
                stepm(bx, 240, "y241_above");
            end
            if (f == 121) begin
                step(bx, 239, 1'b1, 24'hFF0000, "y239_top");
                stepm(bx, 271, "y239_below");
            end
            if (f == 224) begin
                step(449, by, 1'b1, 24'hFF0000, "x449_left");
                step(480, by, 1'b1, 24'hFF0000, "x449_right_col");
                stepm(448, by, "x449_outside");
            end
            if (f == 225) begin
                step(447, by, 1'b1, 24'hFF0000, "x447_left");
                stepm(479, by, "x447_outside");
            end
        end

        // 65536 back-to-back frame ends with the square frozen: counter wraps home.
        run = 1'b0;
        for (int n = 0; n < 65536; n++) begin
            stepm(480, 272, "wrap_px");
        end
        step(0, 0, 1'b1, 24'h000000, "wrap_blank0");
        step(0, 0, 1'b1, 24'h000000, "wrap_blank1");
        check16("wrap_frame_cnt", frame_cnt, fc[15:0]);
        probe_box("after_wrap");
        step(0, 0, 1'b0, 24'h000000, "flush");
        step(0, 0, 1'b0, 24'h000000, "flush");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
